// File: rtl/avg_uart_tx.sv
// avg_uart_tx: queues signed 8-bit moving-average samples in a small FIFO
// and sends each as one 8N1 UART frame (start, 8 data bits LSB first, stop)
// carrying the raw two's-complement byte.
//
// Ports
//   CLK100MHZ     system clock, rising edge
//   reset         synchronous active-high; clears FIFO, FSM and flags
//   start         transmit enable; gates FIFO pops only
//   sample        signed filtered average (sent as its bit pattern)
//   sample_valid  write strobe, one FIFO write per high cycle
//   tx            registered UART line, idles high
//   busy          high while a frame is in START, DATA or STOP
//   fifo_count    occupied FIFO entries
//   fifo_full     fifo_count == FIFO_DEPTH
//   overflow      sticky, set when a write is dropped
module avg_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  sample,
  input  logic                        sample_valid,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic          pop, wr_ok, last;

  // Pop looks at the pre-write count, so an empty FIFO being written this
  // cycle does not pop until the next one. A pop frees a slot, so a write
  // at full is still accepted in the same cycle.
  assign pop   = (state == IDLE) && start && (cnt != '0);
  assign wr_ok = sample_valid && ((cnt != C_FULL) || pop);
  assign cnt_n = cnt + CW'(wr_ok) - CW'(pop);
  assign last  = (timer == T_LAST);

  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_idx;
    shreg_n = shreg;
    case (state)
      IDLE: begin
        if (pop) begin
          state_n = START;
          timer_n = '0;
          shreg_n = mem[rd_ptr];
        end
      end
      START: begin
        if (last) begin
          state_n = DATA;
          timer_n = '0;
          bit_n   = 3'd0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DATA: begin
        if (last) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = shreg >> 1;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        if (last) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
    endcase
    // Line level follows the state being entered so tx is a clean register.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      cnt       <= cnt_n;
      fifo_full <= (cnt_n == C_FULL);
      overflow  <= overflow | (sample_valid & ~wr_ok);
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset && wr_ok) mem[wr_ptr] <= sample;
  end

  assign busy       = (state != IDLE);
  assign fifo_count = cnt;

endmodule

// File: tb/tb_avg_uart_tx.sv
module tb_avg_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       CLK100MHZ = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       sample_valid = 1'b0;
  logic       tx, busy, fifo_full, overflow;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  avg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .sample(sample),
    .sample_valid(sample_valid), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; everything after it observes post-edge values.
  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wr(input logic [7:0] v);
    sample = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    if (tx !== 1'b0) chk("start_timeout", tx, 0);
  endtask

  // Called after the edge that shows frame position 'first' (0 = start bit).
  task automatic expect_frame(input string tag, input logic [7:0] b, input int first);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = first; i < 10*CPB; i++) begin
      chk({tag, "_tx"}, tx, fr[i/CPB]);
      chk({tag, "_busy"}, busy, 1);
      step();
    end
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_tx_gap"}, tx, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    sample_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;

    // Reset held 3 cycles with writes attempted.
    #1;
    reset = 1'b1;
    sample_valid = 1'b1;
    sample = 8'h77;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
    end
    reset = 1'b0;
    sample_valid = 1'b0;
    step();
    chk("rel_tx", tx, 1);
    chk("rel_busy", busy, 0);
    chk("rel_cnt", fifo_count, 0);
    chk("rel_ovf", overflow, 0);

    // Single frame of -10.
    start = 1'b1;
    wr(8'hF6);
    chk("one_cnt_N", fifo_count, 1);
    chk("one_tx_N", tx, 1);
    step();
    chk("one_cnt_N1", fifo_count, 0);
    expect_frame("one", 8'hF6, 0);

    // Burst of 1..10: 10 dropped, frames 1..9 spaced 41 cycles.
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr(8'(k + 1));
      chk("burst_cnt", fifo_count, (k == 0) ? 1 : ((k > 8) ? 8 : k));
      chk("burst_ovf", overflow, (k == 9) ? 1 : 0);
      if (k == 8) chk("burst_full", fifo_full, 1);
    end
    expect_frame("burst1", 8'd1, 8);
    for (int v = 2; v <= 9; v++) begin
      wait_start(n);
      chk("burst_gap", n, 1);
      expect_frame("burstn", 8'(v), 0);
    end
    chk("burst_empty", fifo_count, 0);
    chk("burst_ovf_sticky", overflow, 1);

    // Full with a simultaneous pop and write.
    do_reset();
    chk("full_ovf_clr", overflow, 0);
    for (int k = 0; k < 8; k++) wr(8'h10 + 8'(k));
    chk("full_flag", fifo_full, 1);
    chk("full_cnt", fifo_count, 8);
    chk("full_tx_idle", tx, 1);
    chk("full_busy", busy, 0);
    start = 1'b1;
    wr(8'h55);
    chk("full_pw_cnt", fifo_count, 8);
    chk("full_pw_ovf", overflow, 0);
    chk("full_pw_full", fifo_full, 1);
    expect_frame("full", 8'h10, 0);
    chk("full_after_cnt", fifo_count, 8);

    // start dropped during DATA.
    do_reset();
    wr(8'hA1);
    wr(8'hB2);
    wr(8'hC3);
    start = 1'b1;
    step();
    chk("drop_startbit", tx, 0);
    for (int k = 0; k < 5; k++) step();
    start = 1'b0;
    expect_frame("drop", 8'hA1, 5);
    for (int k = 0; k < 10; k++) begin
      chk("drop_hold_tx", tx, 1);
      chk("drop_hold_busy", busy, 0);
      step();
    end
    chk("drop_cnt", fifo_count, 2);
    start = 1'b1;
    wait_start(n);
    chk("drop_resume_lat", n, 1);
    expect_frame("resume", 8'hB2, 0);

    // Reset during DATA bit 3.
    do_reset();
    wr(8'h3C);
    wr(8'h11);
    wr(8'h22);
    start = 1'b1;
    step();
    chk("rmid_startbit", tx, 0);
    for (int k = 0; k < 17; k++) step();
    chk("rmid_bit3", tx, 1);
    chk("rmid_cnt_pre", fifo_count, 2);
    reset = 1'b1;
    step();
    chk("rmid_tx", tx, 1);
    chk("rmid_busy", busy, 0);
    chk("rmid_cnt", fifo_count, 0);
    reset = 1'b0;
    wr(8'h5A);
    wait_start(n);
    chk("rmid_lat", n, 1);
    expect_frame("rmid", 8'h5A, 0);
    chk("rmid_cnt_end", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
